// File: rtl/modbus_tx_frame_ctrl.sv
// Modbus RTU response-frame sequencer: streams a buffered payload into uart_byte_tx,
// optionally appends CRC16 (define TX_CRC_APPEND_EN), then holds the 3.5-char gap.
module modbus_tx_frame_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 16709,
  parameter int TX_TIMEOUT = 8192
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_len,
  output logic              buf_rd,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CNT_MAX = (GAP_CYCLES > TX_TIMEOUT) ? GAP_CYCLES : TX_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TX_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
`ifdef TX_CRC_APPEND_EN
    ,
    S_CRC_LO,
    S_CRC_HI
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_idx;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              err_set;
  logic              last_byte;

`ifdef TX_CRC_APPEND_EN
  // Which byte the current WAIT_DONE belongs to, so tx_done can route correctly.
  typedef enum logic [1:0] {
    PH_DATA,
    PH_CRC_LO,
    PH_CRC_HI
  } phase_t;

  phase_t      phase;
  logic [15:0] crc;

  function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
`endif

  assign last_byte = (idx == last_idx);
  assign buf_addr  = idx;
  assign busy      = (state != S_IDLE);

  // NOTE: non-blocking (<=) in every clocked block so all registers update from
  // the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, otherwise
  // the paths that skip it would infer latches.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    err_set    = 1'b0;
    buf_rd     = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          if (frame_len != '0) begin
            accept    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_FETCH: begin
        buf_rd    = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = S_SEND;
      S_SEND: begin
        tx_start  = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
`ifdef TX_CRC_APPEND_EN
          case (phase)
            PH_DATA:   state_nxt = last_byte ? S_CRC_LO : S_FETCH;
            PH_CRC_LO: state_nxt = S_CRC_HI;
            default:   state_nxt = S_GAP;
          endcase
`else
          state_nxt = last_byte ? S_GAP : S_FETCH;
`endif
        end else if (cnt == TMO_LAST) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
`ifdef TX_CRC_APPEND_EN
      S_CRC_LO: state_nxt = S_SEND;
      S_CRC_HI: state_nxt = S_SEND;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx       <= '0;
      last_idx  <= '0;
      cnt       <= '0;
      tx_data   <= 8'h00;
      frame_err <= 1'b0;
`ifdef TX_CRC_APPEND_EN
      crc       <= 16'hFFFF;
      phase     <= PH_DATA;
`endif
    end else begin
      frame_err <= err_set;
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx      <= '0;
            last_idx <= frame_len - ADDR_W'(1);
            cnt      <= '0;
`ifdef TX_CRC_APPEND_EN
            crc      <= 16'hFFFF;
            phase    <= PH_DATA;
`endif
          end
        end
        S_LATCH: begin
          tx_data <= buf_rdata;
`ifdef TX_CRC_APPEND_EN
          crc     <= crc16_update(crc, buf_rdata);
`endif
        end
        S_SEND: cnt <= '0;
        S_WAIT_DONE: begin
          if (tx_done) begin
            // Counter restarts here so the gap begins the cycle after tx_done.
            cnt <= '0;
`ifdef TX_CRC_APPEND_EN
            if (phase == PH_DATA && !last_byte) begin
              idx <= idx + ADDR_W'(1);
            end
`else
            if (!last_byte) begin
              idx <= idx + ADDR_W'(1);
            end
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: cnt <= cnt + CNT_W'(1);
`ifdef TX_CRC_APPEND_EN
        S_CRC_LO: begin
          tx_data <= crc[7:0];
          phase   <= PH_CRC_LO;
        end
        S_CRC_HI: begin
          tx_data <= crc[15:8];
          phase   <= PH_CRC_HI;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_tx_frame_ctrl.sv
// Scoreboard bench for modbus_tx_frame_ctrl: a UART/buffer responder, a byte monitor
// and directed frames; honours TX_CRC_APPEND_EN for the expected CRC bytes.
module tb_modbus_tx_frame_ctrl;

  localparam int ADDR_W   = 8;
  localparam int GAP      = 40;
  localparam int TMO      = 64;
  localparam int UART_DLY = 5;
`ifdef TX_CRC_APPEND_EN
  localparam int CRC_BYTES = 2;
`else
  localparam int CRC_BYTES = 0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] frame_len = '0;
  logic              buf_rd;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_rdata = 8'h00;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic       mute = 1'b0;
  int ucnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int last_start_cyc = 0;
  int bytes_seen = 0;
  int exp_frame_bytes = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  modbus_tx_frame_ctrl #(
    .ADDR_W    (ADDR_W),
    .GAP_CYCLES(GAP),
    .TX_TIMEOUT(TMO)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .frame_start(frame_start),
    .frame_len  (frame_len),
    .buf_rd     (buf_rd),
    .buf_addr   (buf_addr),
    .buf_rdata  (buf_rdata),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Buffer and uart_byte_tx stand-ins, driven on the falling edge.
  always @(negedge clk_in) begin
    if (buf_rd) buf_rdata = mem[buf_addr];
    if (rst_in) begin
      ucnt    = 0;
      tx_done = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (ucnt != 0) begin
        ucnt--;
        if (ucnt == 0) begin
          tx_done       = 1'b1;
          last_done_cyc = cyc;
        end
      end
      if (tx_start && !mute) ucnt = UART_DLY;
    end
  end

  // Monitor: pops an expected byte for every tx_start and checks frame completion.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (tx_start) begin
        last_start_cyc = cyc;
        bytes_seen++;
        if (exp_q.size() == 0) check("tx_byte_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
      if (frame_done) begin
        done_cnt++;
        check("gap_cycles", cyc - last_done_cyc, GAP + 1);
        check("frame_byte_count", bytes_seen, exp_frame_bytes);
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] len);
    step();
    frame_start = 1'b1;
    frame_len   = len;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      step();
      n++;
    end
    check("frame_done_seen", done_cnt - start_cnt, 1);
  endtask

  task automatic load_read_req();
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h00;
    mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'h01;
    exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
`ifdef TX_CRC_APPEND_EN
    exp_q.push_back(8'h84); exp_q.push_back(8'h0A);
`endif
    exp_frame_bytes = 6 + CRC_BYTES;
    bytes_seen = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    step();
    step();
    check("reset_outputs", {11'h0, busy, tx_start, buf_rd, frame_done, frame_err, tx_data, buf_addr}, 32'h0);
    rst_in = 1'b0;
    step();
    check("idle_busy", {31'h0, busy}, 0);

    // 1: six-byte read request
    load_read_req();
    pulse_start(8'd6);
    check("t1_busy_after_start", {31'h0, busy}, 1);
    check("t1_fetch_strobe", {23'h0, buf_rd, buf_addr}, 32'h100);
    wait_done(600);
    check("t1_all_bytes_sent", exp_q.size(), 0);
    step();
    check("t1_busy_cleared", {31'h0, busy}, 0);

    // 2: zero-length request is rejected
    e0 = err_cnt;
    pulse_start(8'd0);
    check("t2_frame_err", {31'h0, frame_err}, 1);
    check("t2_busy", {31'h0, busy}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_quiet", {28'h0, busy, tx_start, buf_rd, frame_err}, 0);
    end
    check("t2_err_pulses", err_cnt - e0, 1);

    // 3: second start while busy is ignored
    load_read_req();
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'd6);
    repeat (12) step();
    check("t3_busy_mid", {31'h0, busy}, 1);
    pulse_start(8'd6);
    check("t3_no_err", {31'h0, frame_err}, 0);
    wait_done(600);
    repeat (60) step();
    check("t3_one_done", done_cnt - d0, 1);
    check("t3_no_err_total", err_cnt - e0, 0);
    check("t3_all_bytes_sent", exp_q.size(), 0);

    // 4: transmitter never answers -> timeout
    mute = 1'b1;
    exp_q.push_back(8'h01);
    bytes_seen = 0;
    pulse_start(8'd6);
    n = 0;
    while (!frame_err && n < TMO + 60) begin
      step();
      n++;
    end
    check("t4_timeout_err", {31'h0, frame_err}, 1);
    check("t4_timeout_window",
          {31'h0, (cyc - last_start_cyc >= TMO) && (cyc - last_start_cyc <= TMO + 2)}, 1);
    check("t4_busy_cleared", {31'h0, busy}, 0);
    check("t4_one_byte", bytes_seen, 1);
    mute = 1'b0;
    repeat (3) step();
    load_read_req();
    pulse_start(8'd6);
    wait_done(600);
    check("t4_recovery_bytes", exp_q.size(), 0);

    // 5: reset during the third byte, then a two-byte frame
    exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    bytes_seen = 0;
    pulse_start(8'd6);
    n = 0;
    while (bytes_seen < 3 && n < 200) begin
      step();
      n++;
    end
    check("t5_reached_third_byte", bytes_seen, 3);
    step();
    step();
    check("t5_busy_before_reset", {31'h0, busy}, 1);
    #2 rst_in = 1'b1;
    #1;
    check("t5_async_reset_outputs",
          {11'h0, busy, tx_start, buf_rd, frame_done, frame_err, tx_data, buf_addr}, 32'h0);
    check("t5_first_three_only", exp_q.size(), 0);
    exp_q.delete();
    step();
    step();
    rst_in = 1'b0;
    step();
    mem[0] = 8'h11; mem[1] = 8'h22;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
`ifdef TX_CRC_APPEND_EN
    exp_q.push_back(8'h8D); exp_q.push_back(8'hF9);
`endif
    exp_frame_bytes = 2 + CRC_BYTES;
    bytes_seen = 0;
    pulse_start(8'd2);
    wait_done(400);
    check("t5_all_bytes_sent", exp_q.size(), 0);

`ifndef TX_CRC_APPEND_EN
    // 6: pass-through frame, no CRC appended
    mem[0] = 8'hC2; mem[1] = 8'hB3; mem[2] = 8'hA4; mem[3] = 8'h95;
    exp_q.push_back(8'hC2); exp_q.push_back(8'hB3);
    exp_q.push_back(8'hA4); exp_q.push_back(8'h95);
    exp_frame_bytes = 4;
    bytes_seen = 0;
    pulse_start(8'd4);
    wait_done(400);
    check("t6_all_bytes_sent", exp_q.size(), 0);
`endif

    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modbus_tx_frame_ctrl.md
Name: modbus_tx_frame_ctrl

Overview:
Sequences one Modbus RTU response frame onto the byte transmitter `uart_byte_tx`.
- Reads N payload bytes from a synchronous frame buffer.
- Feeds each byte to the transmitter using the tx_start/tx_data/tx_done handshake.
- Appends the CRC16 low byte, then the high byte.
- Enforces the 3.5-character silent interval before reporting the frame as done.

Sits between the slave's response builder and `uart_byte_tx`.

Parameters:
- ADDR_W, 8, frame buffer address width; maximum payload is 2^ADDR_W-1 bytes.
- GAP_CYCLES, 16709, clock cycles of line silence after the last stop bit. This is 3.5 chars × 11 bits × 434 clk/bit, for 50 MHz at 115200 baud.
- TX_TIMEOUT, 8192, maximum clock cycles allowed from tx_start to tx_done.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous reset, active-high
- frame_start  in  1  one-cycle start request
- frame_len  in  ADDR_W  payload byte count, excluding CRC; sampled on frame_start
- buf_rd  out  1  buffer read strobe
- buf_addr  out  ADDR_W  buffer read address
- buf_rdata  in  8  buffer data, valid the cycle after buf_rd
- tx_start  out  1  one-cycle start pulse to `uart_byte_tx`
- tx_data  out  8  byte to transmit; held stable until tx_done
- tx_done  in  1  one-cycle byte-complete pulse from `uart_byte_tx`
- busy  out  1  high from accepted frame_start until frame_done or frame_err
- frame_done  out  1  one-cycle pulse when the frame and gap are complete
- frame_err  out  1  one-cycle pulse on rejected start or timeout

Behaviour:
- Reset: every output is 0 (tx_data=8'h00, buf_addr=0). The state is IDLE, crc=16'hFFFF and all counters are cleared.
  - Reset mid-frame aborts immediately.
  - Any byte already inside `uart_byte_tx` is not tracked.
- States: IDLE, FETCH, LATCH, SEND, WAIT_DONE, CRC_LO, CRC_HI, GAP, FINISH.
- IDLE:
  - frame_start with frame_len≠0: latch len, set crc=16'hFFFF, idx=0, busy=1, go to FETCH.
  - frame_start with frame_len=0: pulse frame_err, stay in IDLE, busy stays 0.
- FETCH: buf_rd=1, buf_addr=idx for one cycle, then go to LATCH.
- LATCH: tx_data<=buf_rdata; crc<=crc16_update(crc, buf_rdata); go to SEND.
- SEND: tx_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE, on tx_done:
  - if idx<len-1: idx++, go to FETCH.
  - else (payload finished): go to CRC_LO.
  - after CRC_LO's byte: go to CRC_HI.
  - after CRC_HI's byte: go to GAP.
- WAIT_DONE timeout: if the counter reaches TX_TIMEOUT before tx_done, pulse frame_err, clear busy, go to IDLE.
- CRC_LO / CRC_HI: tx_data<=crc[7:0] or crc[15:8] (CRC is not updated), then SEND.
- GAP: count GAP_CYCLES cycles starting the cycle after the final tx_done, then go to FINISH.
- FINISH: frame_done=1 for one cycle, busy<=0, go to IDLE.
  - frame_start in the same cycle as FINISH is ignored.
  - frame_start is accepted from the following cycle.
- frame_start while busy: ignored, no error.
- tx_done outside WAIT_DONE: ignored.
- CRC16/Modbus:
  - reflected polynomial 16'hA001, init 16'hFFFF, 8 shift/xor steps per byte, computed combinationally in one cycle.
  - Low byte is transmitted first.
- Per-byte overhead: 3 cycles (FETCH, LATCH, SEND) plus the UART byte time.
- Maximum frame_len: 2^ADDR_W-1; idx never wraps.

Optional Feature:
Macro: TX_CRC_APPEND_EN
- Defined: CRC_LO and CRC_HI are sent after the payload, as described above.
- Undefined:
  - CRC states and CRC logic are compiled out.
  - After the last payload tx_done the block goes straight to GAP.
  - Exactly frame_len bytes appear on the line, for passing through frames whose CRC was prebuilt in the buffer.

Test Plan:
1. Buffer holds 01 03 00 00 00 01; frame_start, len=6 → line carries 01 03 00 00 00 01 84 0A; 8 tx_start pulses; frame_done exactly GAP_CYCLES+1 cycles after the 8th tx_done.
2. len=0 → frame_err pulse in the next cycle; busy, tx_start and buf_rd stay 0.
3. Second frame_start mid-frame (len=6) → ignored; exactly 8 bytes are sent and one frame_done pulses.
4. Stubbed tx_done never asserted → frame_err after TX_TIMEOUT cycles; busy=0; a following valid frame transmits correctly.
5. rst_in asserted during the 3rd byte → all outputs 0 asynchronously; after release, a new len=2 frame (11 22) sends 11 22 plus its CRC.
6. TX_CRC_APPEND_EN undefined, len=4 (C2 B3 A4 95) → exactly 4 bytes C2 B3 A4 95, then the gap, then frame_done.
